// File: rtl/j1a_pkg.sv
// j1a_pkg: opcode, return-stack delta and sequencer state definitions shared across the j1a core
package j1a_pkg;
  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_JZ = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_ALU = 3'b011;
  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_PUSH = 2'b01;
  localparam logic [1:0] RD_POP = 2'b11;
  typedef enum logic [1:0] {BOOT, EXEC, RET_WAIT} state_t;
endpackage

// File: rtl/j1a_pc_seq_if.sv
// j1a_pc_seq_if: strobe/data link between the pc sequencer and the return stack
interface j1a_pc_seq_if #(parameter int DATA_W = 16);
  logic rs_push;
  logic rs_pop;
  logic [DATA_W-1:0] rs_in;
  logic [DATA_W-1:0] rs_out;
  modport master(output rs_push, rs_pop, rs_in, input rs_out);
  modport slave(input rs_push, rs_pop, rs_in, output rs_out);
endinterface

// File: rtl/j1a_rdepth_mon.sv
// j1a_rdepth_mon: stack depth counter with sticky overflow/underflow flags
module j1a_rdepth_mon #(parameter int DEPTH = 7) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  output logic [DEPTH:0] depth,
  output logic overflow,
  output logic underflow
);
  localparam logic [DEPTH:0] FULL = {1'b1, {DEPTH{1'b0}}};
  logic [DEPTH:0] r_depth;
  logic r_ovf, r_unf;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (push) begin
      r_depth <= r_depth + 1'b1;
      r_ovf <= r_ovf | (r_depth == FULL);
    end else if (pop) begin
      r_depth <= r_depth - 1'b1;
      r_unf <= r_unf | (r_depth == '0);
    end
  end
  assign depth = r_depth;
  assign overflow = r_ovf;
  assign underflow = r_unf;
endmodule

// File: rtl/j1a_pc_seq.sv
// j1a_pc_seq: program-counter sequencer driving the j1a return stack
module j1a_pc_seq
  import j1a_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] insn,
  input  logic [DATA_W-1:0] tos,
  output logic [ADDR_W-1:0] pc,
  j1a_pc_seq_if.master rs,
  output logic [DEPTH:0] rdepth,
  output logic r_overflow,
  output logic r_underflow
);
  state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc, w_next, w_inc, w_tgt;
  logic [DATA_W-1:0] w_rs_in;
  logic w_push, w_pop, w_gate, w_unused;
  assign w_inc = r_pc + 1'b1;
  assign w_tgt = insn[ADDR_W-1:0];
  assign w_gate = ~stall & ~reset;
  assign w_unused = ^rs.rs_out[DATA_W-1:ADDR_W];
  // literals (insn msb set) fall through to the default pc+1 path
  always_comb begin
    w_push = 1'b0;
    w_pop = 1'b0;
    w_rs_in = tos;
    w_next = w_inc;
    w_state_nx = r_state;
    case (r_state)
      BOOT: begin
        w_next = '0;
        w_state_nx = EXEC;
      end
      RET_WAIT: begin
        w_next = rs.rs_out[ADDR_W-1:0];
        w_state_nx = EXEC;
      end
      default:
        case (insn[DATA_W-1 -: 3])
          OP_JMP: w_next = w_tgt;
          OP_JZ: w_next = (tos == '0) ? w_tgt : w_inc;
          OP_CALL: begin
            w_push = 1'b1;
            w_rs_in = {{(DATA_W-ADDR_W){1'b0}}, w_inc};
            w_next = w_tgt;
          end
          OP_ALU: begin
            w_pop = insn[12] | (insn[3:2] == RD_POP);
            w_push = ~insn[12] & (insn[3:2] == RD_PUSH);
            w_next = insn[12] ? r_pc : w_inc;
            w_state_nx = insn[12] ? RET_WAIT : EXEC;
          end
          default: ;
        endcase
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc <= '0;
    end else if (!stall) begin
      r_state <= w_state_nx;
      r_pc <= w_next;
    end
  end
  assign imem_addr = reset ? '0 : (stall && r_state != RET_WAIT) ? r_pc : w_next;
  assign pc = r_pc;
  assign rs.rs_push = w_push & w_gate;
  assign rs.rs_pop = w_pop & w_gate;
  assign rs.rs_in = w_rs_in;
  j1a_rdepth_mon #(.DEPTH(DEPTH)) u_rdepth (
    .clk(clk),
    .reset(reset),
    .push(rs.rs_push),
    .pop(rs.rs_pop),
    .depth(rdepth),
    .overflow(r_overflow),
    .underflow(r_underflow)
  );
endmodule

// File: tb/tb_j1a_pc_seq.sv
// tb_j1a_pc_seq: directed and randomized checks of the pc sequencer against an instruction-level model
module tb_j1a_pc_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic [15:0] insn = '0;
  logic [15:0] tos = '0;
  logic [12:0] imem_addr, pc;
  logic [7:0] rdepth;
  logic r_overflow, r_underflow;
  int checks = 0;
  int failures = 0;
  bit m_valid = 0, m_boot = 1, m_ret = 0, m_ovf = 0, m_unf = 0;
  logic [12:0] m_pc = '0;
  int m_depth = 0;
  logic [15:0] rstk[$];

  j1a_pc_seq_if #(.DATA_W(16)) rs_if ();

  j1a_pc_seq #(.ADDR_W(13), .DATA_W(16), .DEPTH(7)) dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_addr(imem_addr), .insn(insn), .tos(tos),
    .pc(pc), .rs(rs_if), .rdepth(rdepth), .r_overflow(r_overflow), .r_underflow(r_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, check outputs mid-cycle, then advance the model
  task automatic step(input logic [15:0] i, input logic [15:0] t, input bit s, input bit r);
    logic [12:0] np, ea;
    logic [15:0] ei;
    bit ep, eo, to_ret;
    insn = i; tos = t; stall = s; reset = r;
    #4;
    ep = 0; eo = 0; ei = '0; to_ret = 0;
    if (m_boot) np = '0;
    else if (m_ret) np = rs_if.rs_out[12:0];
    else begin
      np = m_pc + 13'd1;
      if (i[15] == 1'b0) begin
        case (int'(i[14:13]))
          0: np = i[12:0];
          1: if (t == 16'd0) np = i[12:0];
          2: begin ep = 1; ei = {3'b000, 13'(m_pc + 13'd1)}; np = i[12:0]; end
          default:
            if (i[12]) begin eo = 1; np = m_pc; to_ret = 1; end
            else if (i[3:2] == 2'b01) begin ep = 1; ei = t; end
            else if (i[3:2] == 2'b11) eo = 1;
        endcase
      end
    end
    ea = np;
    if (s) begin ep = 0; eo = 0; ea = m_ret ? rs_if.rs_out[12:0] : m_pc; end
    if (r) begin ep = 0; eo = 0; ea = '0; end
    chk("imem_addr", 32'(imem_addr), 32'(ea));
    chk("rs_push", 32'(rs_if.rs_push), 32'(ep));
    chk("rs_pop", 32'(rs_if.rs_pop), 32'(eo));
    if (ep) chk("rs_in", 32'(rs_if.rs_in), 32'(ei));
    if (m_valid) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("rdepth", 32'(rdepth), 32'(m_depth));
      chk("r_overflow", 32'(r_overflow), 32'(m_ovf));
      chk("r_underflow", 32'(r_underflow), 32'(m_unf));
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1; m_boot = 1; m_ret = 0; m_pc = '0; m_depth = 0; m_ovf = 0; m_unf = 0;
      rstk.delete();
    end else if (!s) begin
      if (ep) begin
        if (m_depth == 128) m_ovf = 1;
        m_depth = (m_depth + 1) % 256;
        rstk.push_back(ei);
      end
      if (eo) begin
        if (m_depth == 0) m_unf = 1;
        m_depth = (m_depth + 255) % 256;
        rs_if.rs_out = (rstk.size() > 0) ? rstk.pop_back() : 16'($urandom);
      end
      m_pc = np; m_boot = 0; m_ret = to_ret;
    end
  endtask

  initial begin
    rs_if.rs_out = '0;
    step(16'h4100, 16'h0, 0, 1);
    step(16'h7000, 16'h0, 1, 1);
    step(16'h4100, 16'h0, 0, 0);
    repeat (3) step(16'h8001, 16'h0, 0, 0);
    chk("pc_after_lits", 32'(pc), 32'h3);
    step(16'h0005, 16'h0, 0, 0);
    step(16'h4100, 16'h0, 0, 0);
    chk("call_target", 32'(pc), 32'h100);
    step(16'h7000, 16'h0, 0, 0);
    step(16'h4123, 16'h0, 0, 0);
    chk("ret_pc", 32'(pc), 32'h6);
    step(16'h2020, 16'h0, 0, 0);
    step(16'h2020, 16'h5, 0, 0);
    step(16'h6004, 16'hBEEF, 0, 0);
    step(16'h600C, 16'h0, 0, 0);
    step(16'h1FFF, 16'h0, 0, 0);
    step(16'h8001, 16'h0, 0, 0);
    chk("pc_wrap", 32'(pc), 32'h0);
    step(16'h0, 16'h0, 0, 1);
    step(16'h0, 16'h0, 0, 0);
    repeat (129) step(16'h4100, 16'h1234, 0, 0);
    chk("ovf_set", 32'(r_overflow), 32'h1);
    step(16'h8001, 16'h0, 0, 1);
    step(16'h8001, 16'h0, 0, 0);
    step(16'h7000, 16'h0, 0, 0);
    step(16'h8001, 16'h0, 0, 0);
    repeat (3) step(16'h8001, 16'h0, 0, 0);
    chk("unf_sticky", 32'(r_underflow), 32'h1);
    step(16'h4200, 16'h0, 0, 0);
    step(16'h7000, 16'h0, 0, 0);
    repeat (3) step(16'h4321, 16'h0, 1, 0);
    step(16'h4321, 16'h0, 1, 1);
    chk("stall_reset_unf", 32'(r_underflow), 32'h0);
    step(16'h8001, 16'h0, 0, 0);
    repeat (400)
      step(16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
